// File: rtl/text_uart_pkg.sv
// Shared constants for the UART text link: screen geometry, control codes,
// formatter state encoding and the row-advance helper.
package text_uart_pkg;

    localparam int unsigned TEXT_COLS = 106;
    localparam int unsigned TEXT_ROWS = 30;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_SEND_LF
    } fmt_state_e;

    function automatic logic [4:0] next_row(input logic [4:0] y);
        return (y == 5'(TEXT_ROWS - 1)) ? 5'd0 : y + 5'd1;
    endfunction

endpackage

// File: rtl/uart_text_sender_serializer.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each held
// CLKS_PER_BIT cycles. A start in the final stop cycle chains the next frame.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [8:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             load;

    always_comb begin
        bit_end   = active_q && (cnt_q == CNT_LAST);
        done      = bit_end && (bit_idx_q == 4'd9);
        load      = start && (!active_q || done);
        active_d  = active_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        if (load) begin
            active_d  = 1'b1;
            cnt_d     = '0;
            bit_idx_d = '0;
            shift_d   = {1'b1, data};
            tx_d      = 1'b0;
        end else if (done) begin
            active_d  = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            tx_d      = 1'b1;
        end else if (bit_end) begin
            // shift register carries the stop bit in behind the data
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
        end else if (active_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
        end else begin
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_text_sender.sv
// UART text sender: byte FIFO, formatter FSM and far-end cursor mirror.
// Optional macro TEXT_TX_CRLF_EN expands each LF into a CR frame then an LF frame.
module uart_text_sender
    import text_uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       tx,
    output logic       busy,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [6:0] COL_LAST = 7'(TEXT_COLS - 1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fmt_state_e       state_q, state_d;
    logic             lf_pending_q, lf_pending_d;
    logic [7:0]       cur_byte_q, cur_byte_d;
    logic [6:0]       cx_q, cx_d;
    logic [4:0]       cy_q, cy_d;

    logic       push, pop, not_empty, expand;
    logic       fetch, send_lf;
    logic       ser_start, ser_done;
    logic [7:0] ser_data, head;

    assign not_empty  = (count_q != '0);
    assign char_ready = (count_q != FULL_COUNT);
    assign push       = char_valid && char_ready;
    assign head       = mem_q[rd_ptr_q];

`ifdef TEXT_TX_CRLF_EN
    assign expand = (head == ASCII_LF);
`else
    assign expand = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A queued byte is fetched during the final stop cycle so frames chain
    // without a gap; FETCH itself is only visited when leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (not_empty) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                if (ser_done) begin
                    if (lf_pending_q)   state_d = ST_SEND_LF;
                    else if (not_empty) state_d = ST_SEND;
                    else                state_d = ST_IDLE;
                end
            end
            ST_SEND_LF: begin
                if (ser_done) state_d = not_empty ? ST_SEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch   = 1'b0;
        send_lf = 1'b0;
        case (state_q)
            ST_FETCH: fetch = 1'b1;
            ST_SEND: begin
                send_lf = ser_done && lf_pending_q;
                fetch   = ser_done && !lf_pending_q && not_empty;
            end
            ST_SEND_LF: fetch = ser_done && not_empty;
            default: ;
        endcase
        pop          = fetch;
        ser_start    = fetch || send_lf;
        ser_data     = fetch ? (expand ? ASCII_CR : head) : ASCII_LF;
        cur_byte_d   = ser_start ? ser_data : cur_byte_q;
        lf_pending_d = fetch ? expand : (send_lf ? 1'b0 : lf_pending_q);
    end

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (ser_done) begin
            if (cur_byte_q == ASCII_CR) begin
                cx_d = '0;
            end else if (cur_byte_q == ASCII_LF) begin
                cy_d = next_row(cy_q);
            end else if (cx_q == COL_LAST) begin
                cx_d = '0;
                cy_d = next_row(cy_q);
            end else begin
                cx_d = cx_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lf_pending_q <= 1'b0;
            cur_byte_q   <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lf_pending_q <= lf_pending_d;
            cur_byte_q   <= cur_byte_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(ser_start),
        .data (ser_data),
        .tx   (tx),
        .done (ser_done)
    );

    assign busy     = not_empty || (state_q != ST_IDLE);
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;

endmodule

// File: tb/tb_uart_text_sender.sv
// Bench for uart_text_sender: a line monitor decodes tx frames and a
// spec-level model predicts frame bytes and the cursor position.
module tb_uart_text_sender;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       tx;
    logic       busy;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    uart_text_sender #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .tx        (tx),
        .busy      (busy),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  b;
        logic        ok;
        int unsigned t0;
    } frame_t;

    frame_t      mon_q[$];
    logic [7:0]  exp_q[$];
    int unsigned mx = 0;
    int unsigned my = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Line monitor: samples each bit in its middle, drops frames cut by reset.
    initial begin
        frame_t     f;
        logic [9:0] bits;
        bit         aborted;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                f.t0 = cyc;
                bits = '0;
                aborted = 1'b0;
                for (int c = 1; c < int'(CPB) * 10; c++) begin
                    @(posedge clk);
                    #1;
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    if (c % int'(CPB) == int'(CPB) / 2) bits[c / int'(CPB)] = tx;
                end
                f.b  = bits[8:1];
                f.ok = (bits[0] === 1'b0) && (bits[9] === 1'b1);
                if (!aborted) mon_q.push_back(f);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] f);
        exp_q.push_back(f);
        if (f == 8'h0D) begin
            mx = 0;
        end else if (f == 8'h0A) begin
            my = (my + 1) % 30;
        end else if (mx == 105) begin
            mx = 0;
            my = (my + 1) % 30;
        end else begin
            mx = mx + 1;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
`ifdef TEXT_TX_CRLF_EN
        if (b == 8'h0A) begin
            model_frame(8'h0D);
            model_frame(8'h0A);
        end else begin
            model_frame(b);
        end
`else
        model_frame(b);
`endif
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        mx = 0;
        my = 0;
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bit          acc = 1'b0;
        char_valid = 1'b1;
        char_data  = b;
        while (!acc && n < 5000) begin
            acc = char_ready;
            tick();
            n++;
        end
        char_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
        else model_push(b);
    endtask

    task automatic wait_idle(input string tag, input int unsigned limit);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_drain"}, 32'(busy), 32'd0);
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_nframes"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk({tag, "_byte"}, 32'(mon_q[i].b), 32'(exp_q[i]));
            chk({tag, "_framing"}, 32'(mon_q[i].ok), 32'd1);
        end
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_cx"}, 32'(cursor_x), 32'(mx));
        chk({tag, "_cy"}, 32'(cursor_y), 32'(my));
    endtask

    initial begin
        logic [9:0]  fb;
        logic [7:0]  burst[20];
        logic [7:0]  r;
        int unsigned i;
        int unsigned n;
        int          acc_at_drop;
        bit          seen_drop;
        bit          rdy;
        bit          bad;

        // Reset values, observed while reset is held
        rst_n = 1'b0;
        #2;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(char_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cx", 32'(cursor_x), 32'd0);
        chk("rst_cy", 32'(cursor_y), 32'd0);

        // 1: single 0x41, cycle-exact waveform relative to accept edge k=0
        do_reset();
        char_valid = 1'b1;
        char_data  = 8'h41;
        tick();
        char_valid = 1'b0;
        model_push(8'h41);
        fb = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k <= 110; k++) begin
            if (k > 0) tick();
            chk("t1_tx", 32'(tx), (k >= 2 && k < 102) ? 32'(fb[(k - 2) / 10]) : 32'd1);
            chk("t1_cx", 32'(cursor_x), (k >= 102) ? 32'd1 : 32'd0);
            chk("t1_busy", 32'(busy), (k < 102) ? 32'd1 : 32'd0);
        end
        cmp_frames("t1");

        // 2: burst of 20 random bytes with char_valid held
        do_reset();
        for (int j = 0; j < 20; j++) burst[j] = 8'($urandom);
        i = 0;
        n = 0;
        acc_at_drop = -1;
        seen_drop = 1'b0;
        char_valid = 1'b1;
        char_data = burst[0];
        while (i < 20 && n < 5000) begin
            rdy = char_ready;
            tick();
            n++;
            if (rdy) begin
                model_push(burst[i]);
                i++;
            end else if (!seen_drop) begin
                seen_drop = 1'b1;
                acc_at_drop = int'(i);
            end
            if (i < 20) char_data = burst[i];
        end
        char_valid = 1'b0;
        chk("t2_accepted_before_full", 32'(acc_at_drop), 32'd17);
        wait_idle("t2", 8000);
        cmp_frames("t2");
        for (int j = 1; j < mon_q.size(); j++) begin
            chk("t2_contiguous", 32'(mon_q[j].t0 - mon_q[j - 1].t0), 32'(CPB * 10));
        end
        chk_cursor("t2");

        // 3: column wrap after 106 printable bytes
        do_reset();
        for (int j = 0; j < 105; j++) send_byte(8'h41);
        wait_idle("t3a", 20000);
        chk("t3_cx_105", 32'(cursor_x), 32'd105);
        chk("t3_cy_0", 32'(cursor_y), 32'd0);
        send_byte(8'h41);
        wait_idle("t3b", 2000);
        chk("t3_cx_wrap", 32'(cursor_x), 32'd0);
        chk("t3_cy_wrap", 32'(cursor_y), 32'd1);
        cmp_frames("t3");

        // 4: line feed at (5,3)
        do_reset();
        for (int j = 0; j < 3; j++) send_byte(8'h0A);
        for (int j = 0; j < 5; j++) send_byte(8'($urandom_range(8'h20, 8'h7E)));
        wait_idle("t4a", 5000);
        chk("t4_pre_cx", 32'(cursor_x), 32'd5);
        chk("t4_pre_cy", 32'(cursor_y), 32'd3);
        mon_q.delete();
        exp_q.delete();
        send_byte(8'h0A);
        wait_idle("t4b", 2000);
        cmp_frames("t4");
`ifdef TEXT_TX_CRLF_EN
        chk("t4_cx", 32'(cursor_x), 32'd0);
`else
        chk("t4_cx", 32'(cursor_x), 32'd5);
`endif
        chk("t4_cy", 32'(cursor_y), 32'd4);

        // 5: row wrap from y=29 via CR LF
        do_reset();
        for (int j = 0; j < 29; j++) send_byte(8'h0A);
        wait_idle("t5a", 10000);
        chk("t5_pre_cy", 32'(cursor_y), 32'd29);
        send_byte(8'h0D);
        send_byte(8'h0A);
        wait_idle("t5b", 2000);
        chk("t5_cx", 32'(cursor_x), 32'd0);
        chk("t5_cy", 32'(cursor_y), 32'd0);
        cmp_frames("t5");

        // Randomised traffic with control codes and idle gaps
        do_reset();
        for (int j = 0; j < 24; j++) begin
            case ($urandom_range(0, 9))
                0:       r = 8'h0A;
                1:       r = 8'h0D;
                default: r = 8'($urandom_range(8'h20, 8'h7E));
            endcase
            send_byte(r);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(20, 150)) tick();
        end
        wait_idle("rnd", 20000);
        cmp_frames("rnd");
        chk_cursor("rnd");

        // 6: reset during data bit 3
        do_reset();
        char_valid = 1'b1;
        char_data  = 8'h5A;
        tick();
        char_valid = 1'b0;
        repeat (45) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_tx_async", 32'(tx), 32'd1);
        chk("t6_ready", 32'(char_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cx", 32'(cursor_x), 32'd0);
        chk("t6_cy", 32'(cursor_y), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        bad = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || char_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        chk("t6_quiet_after_reset", 32'(bad), 32'd0);
        chk("t6_no_residual_frame", 32'(mon_q.size()), 32'd0);
        chk("t6_cursor_after", 32'({cursor_x, cursor_y}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
